// File: rtl/legv8_decode_stage_pkg.sv
// legv8_pkg: shared op codes, opcode-field patterns and the decoded control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: op_e (4-bit op code), PAT_* opcode-field patterns, dec_t (op, register indices, control flags).
package legv8_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDUR = 4'd1,
    OP_STUR = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_ADDI = 4'd5,
    OP_SUBI = 4'd6,
    OP_AND  = 4'd7,
    OP_ORR  = 4'd8,
    OP_CBZ  = 4'd9,
    OP_CBNZ = 4'd10,
    OP_B    = 4'd11
  } op_e;

  // D-format and R-format compare inst[31:21]
  localparam logic [10:0] PAT_STUR = 11'b11111000000;
  localparam logic [10:0] PAT_LDUR = 11'b11111000010;
  localparam logic [10:0] PAT_ADD  = 11'b10001011000;
  localparam logic [10:0] PAT_SUB  = 11'b11001011000;
  localparam logic [10:0] PAT_AND  = 11'b10001010000;
  localparam logic [10:0] PAT_ORR  = 11'b10101010000;
  // I-format compares inst[31:22]
  localparam logic [9:0]  PAT_ADDI = 10'b1001000100;
  localparam logic [9:0]  PAT_SUBI = 10'b1101000100;
  // CB-format compares inst[31:24]
  localparam logic [7:0]  PAT_CBZ  = 8'b10110100;
  localparam logic [7:0]  PAT_CBNZ = 8'b10110101;
  // B-format compares inst[31:26]
  localparam logic [5:0]  PAT_B    = 6'b000101;

  // Width-independent part of a decoded instruction; the immediate and the
  // branch target are carried beside it because their widths are parameters.
  typedef struct packed {
    op_e        op;
    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       is_branch;
    logic       alu_imm;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/legv8_decode_stage_if.sv
// legv8_decode_stage_if: fetch-side and downstream-side handshake bundle of the decode stage.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready toward fetch, out_valid/out_ready toward execute.
// Modports: slave = decode stage (consumes in_*, drives out_*), master = surrounding pipeline.
interface legv8_decode_stage_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) ();

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [ADDR_W-1:0] in_pc;

  logic              out_valid;
  logic              out_ready;
  legv8_pkg::op_e    out_op;
  logic [4:0]        out_rd;
  logic [4:0]        out_rn;
  logic [4:0]        out_rm;
  logic [DATA_W-1:0] out_imm;
  logic [ADDR_W-1:0] out_br_target;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_is_branch;
  logic              out_alu_imm;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready,
    output out_valid, out_op, out_rd, out_rn, out_rm, out_imm, out_br_target,
    output out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_alu_imm, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready,
    input  out_valid, out_op, out_rd, out_rn, out_rm, out_imm, out_br_target,
    input  out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_alu_imm, out_illegal
  );

endinterface

// File: rtl/legv8_decode_comb.sv
// legv8_decode_comb: combinational LEGv8 subset decoder, instruction + PC -> decoded bundle.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage owns all flow control.
// Ports: i_inst/i_pc in; o_dec (op, regs, flags), o_imm (extended immediate), o_br_target out.
module legv8_decode_comb
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic [31:0]       i_inst,
  input  logic [ADDR_W-1:0] i_pc,
  output dec_t              o_dec,
  output logic [DATA_W-1:0] o_imm,
  output logic [ADDR_W-1:0] o_br_target
);

  logic [ADDR_W-1:0] w_off;  // branch offset in instruction units, extended to PC width

  // Pattern checks run in priority order; the groups are disjoint so order only
  // matters for readability. Sign extension uses a size cast of a signed field.
  always_comb begin
    o_dec     = '0;
    o_dec.op  = OP_NOP;
    o_dec.rd  = i_inst[4:0];
    o_dec.rn  = i_inst[9:5];
    o_dec.rm  = i_inst[20:16];
    o_imm     = '0;
    w_off     = '0;
    if (i_inst[31:21] == PAT_STUR) begin
      o_dec.op        = OP_STUR;
      o_dec.mem_write = 1'b1;
      o_dec.alu_imm   = 1'b1;
      o_imm           = DATA_W'($signed(i_inst[20:12]));
    end else if (i_inst[31:21] == PAT_LDUR) begin
      o_dec.op        = OP_LDUR;
      o_dec.mem_read  = 1'b1;
      o_dec.reg_write = 1'b1;
      o_dec.alu_imm   = 1'b1;
      o_imm           = DATA_W'($signed(i_inst[20:12]));
    end else if (i_inst[31:22] == PAT_ADDI || i_inst[31:22] == PAT_SUBI) begin
      o_dec.op        = (i_inst[31:22] == PAT_ADDI) ? OP_ADDI : OP_SUBI;
      o_dec.reg_write = 1'b1;
      o_dec.alu_imm   = 1'b1;
      o_imm           = DATA_W'(i_inst[21:10]);
    end else if (i_inst[31:21] == PAT_ADD) begin
      o_dec.op        = OP_ADD;
      o_dec.reg_write = 1'b1;
    end else if (i_inst[31:21] == PAT_SUB) begin
      o_dec.op        = OP_SUB;
      o_dec.reg_write = 1'b1;
    end else if (i_inst[31:21] == PAT_AND) begin
      o_dec.op        = OP_AND;
      o_dec.reg_write = 1'b1;
    end else if (i_inst[31:21] == PAT_ORR) begin
      o_dec.op        = OP_ORR;
      o_dec.reg_write = 1'b1;
    end else if (i_inst[31:24] == PAT_CBZ || i_inst[31:24] == PAT_CBNZ) begin
      o_dec.op        = (i_inst[31:24] == PAT_CBZ) ? OP_CBZ : OP_CBNZ;
      o_dec.is_branch = 1'b1;
      o_imm           = DATA_W'($signed(i_inst[23:5]));
      w_off           = ADDR_W'($signed(i_inst[23:5]));
    end else if (i_inst[31:26] == PAT_B) begin
      o_dec.op        = OP_B;
      o_dec.is_branch = 1'b1;
      o_imm           = DATA_W'($signed(i_inst[25:0]));
      w_off           = ADDR_W'($signed(i_inst[25:0]));
    end else begin
      // All-zero word is a deliberate NOP; anything else unmatched is flagged.
      o_dec.illegal   = (i_inst != 32'h0);
    end
  end

  // Word offset to byte offset; the add wraps modulo 2^ADDR_W by construction.
  assign o_br_target = o_dec.is_branch ? (i_pc + (w_off << 2)) : '0;

endmodule

// File: rtl/legv8_decode_stage.sv
// legv8_decode_stage: registered LEGv8 decode stage between fetch and register-read/execute.
// Latency: 1 cycle from input transfer to out_valid; FIFO order, 1 instruction/cycle.
// Backpressure: SKID=1 parks one extra entry and registers in_ready (=!skid_full); SKID=0 uses in_ready = !out_valid || out_ready.
// Ports: clk, rst_n (sync, active low), flush, bus (slave modport: in_* handshake/data, out_* decoded bundle).
module legv8_decode_stage
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int SKID   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  legv8_decode_stage_if.slave  bus
);

  dec_t              w_dec;
  logic [DATA_W-1:0] w_imm;
  logic [ADDR_W-1:0] w_tgt;

  logic              r_main_vld;
  dec_t              r_main_dec;
  logic [DATA_W-1:0] r_main_imm;
  logic [ADDR_W-1:0] r_main_tgt;
  logic              r_skid_vld;
  dec_t              r_skid_dec;
  logic [DATA_W-1:0] r_skid_imm;
  logic [ADDR_W-1:0] r_skid_tgt;
  logic              r_in_rdy;

  logic              w_in_rdy;
  logic              w_in_xfer;
  logic              w_out_xfer;

  legv8_decode_comb #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dec (
    .i_inst      (bus.in_inst),
    .i_pc        (bus.in_pc),
    .o_dec       (w_dec),
    .o_imm       (w_imm),
    .o_br_target (w_tgt)
  );

  // r_in_rdy is held at 1 through reset; gating with rst_n keeps in_ready low
  // while reset is asserted and high in the first cycle after release.
  assign w_in_rdy   = rst_n && ((SKID != 0) ? r_in_rdy : (!r_main_vld || bus.out_ready));
  assign w_in_xfer  = bus.in_valid && w_in_rdy && !flush;
  assign w_out_xfer = r_main_vld && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_vld <= 1'b0;
      r_main_dec <= '0;
      r_main_imm <= '0;
      r_main_tgt <= '0;
      r_skid_vld <= 1'b0;
      r_skid_dec <= '0;
      r_skid_imm <= '0;
      r_skid_tgt <= '0;
      r_in_rdy   <= 1'b1;
    end else if (flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_rdy   <= 1'b1;
    end else if (!r_main_vld || w_out_xfer) begin
      // Main register frees up: the older skid entry goes first. in_ready was
      // low while the skid was full, so no input can arrive in that cycle.
      if (r_skid_vld) begin
        r_main_vld <= 1'b1;
        r_main_dec <= r_skid_dec;
        r_main_imm <= r_skid_imm;
        r_main_tgt <= r_skid_tgt;
        r_skid_vld <= 1'b0;
        r_in_rdy   <= 1'b1;
      end else begin
        r_main_vld <= w_in_xfer;
        if (w_in_xfer) begin
          r_main_dec <= w_dec;
          r_main_imm <= w_imm;
          r_main_tgt <= w_tgt;
        end
      end
    end else if (w_in_xfer) begin
      // Main stalled and an input was already promised: park it. Only
      // reachable with SKID=1 since the combinational in_ready is low here.
      r_skid_vld <= 1'b1;
      r_skid_dec <= w_dec;
      r_skid_imm <= w_imm;
      r_skid_tgt <= w_tgt;
      r_in_rdy   <= 1'b0;
    end
  end

  assign bus.in_ready      = w_in_rdy;
  assign bus.out_valid     = r_main_vld;
  assign bus.out_op        = r_main_dec.op;
  assign bus.out_rd        = r_main_dec.rd;
  assign bus.out_rn        = r_main_dec.rn;
  assign bus.out_rm        = r_main_dec.rm;
  assign bus.out_imm       = r_main_imm;
  assign bus.out_br_target = r_main_tgt;
  assign bus.out_reg_write = r_main_dec.reg_write;
  assign bus.out_mem_read  = r_main_dec.mem_read;
  assign bus.out_mem_write = r_main_dec.mem_write;
  assign bus.out_is_branch = r_main_dec.is_branch;
  assign bus.out_alu_imm   = r_main_dec.alu_imm;
  assign bus.out_illegal   = r_main_dec.illegal;

endmodule

// File: doc/legv8_decode_stage.md
Name: legv8_decode_stage

Overview:
- Registered LEGv8 instruction-decode pipeline stage between the fetch and register-read/execute stages.
- Decodes the supported subset into a compact op code, register indices, an extended immediate, control flags and a resolved branch target.
- Valid/ready handshake on both sides, optional skid buffer for full throughput with a registered in_ready, and a synchronous flush.
- Successor to the combinational decoder: parametrised widths, handshakes, buffering, sign extension, target computation and illegal-instruction flagging.

Parameters:
- DATA_W, 64, width of out_imm (extended immediate).
- ADDR_W, 64, width of PC and branch target.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard all held and incoming instructions this cycle
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts an instruction
- in_inst  in  32  instruction word
- in_pc  in  ADDR_W  PC of in_inst
- out_valid  out  1  decoded instruction available
- out_ready  in  1  downstream accepts
- out_op  out  4  op code (package enum)
- out_rd  out  5  destination / Rt, inst[4:0]
- out_rn  out  5  inst[9:5]
- out_rm  out  5  inst[20:16]
- out_imm  out  DATA_W  extended immediate
- out_br_target  out  ADDR_W  PC-relative target
- out_reg_write  out  1  writes a register (LDUR, ALU ops)
- out_mem_read  out  1  LDUR
- out_mem_write  out  1  STUR
- out_is_branch  out  1  CBZ, CBNZ, B
- out_alu_imm  out  1  ALU operand B is out_imm (LDUR, STUR, ADDI, SUBI)
- out_illegal  out  1  unrecognised non-zero word

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0; all out_* data and flags = 0 (out_op=OP_NOP). in_ready=1 in the cycle after reset; in_ready=0 while rst_n=0. Reset mid-stream drops all held entries.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Latency: accepted instruction appears on out_* in the next cycle. Outputs stay stable while out_valid && !out_ready.
- Ordering is strictly FIFO.
- SKID=1:
  - Main register plus skid register.
  - If out_ready is low while the main register is full and an input transfer occurs, that input goes to the skid register.
  - in_ready is registered: in_ready = !skid_full.
  - Sustains 1 instruction/cycle.
- SKID=0: single register, combinational in_ready.
- Flush: clears out_valid and the skid entry at the next edge, and ignores any same-cycle input transfer. Flush has priority over in/out transfers.
- Decode, first match wins on opcode field; rd/rn/rm always copied raw:
  - inst[31:21]=11111000000 STUR: imm = sext(inst[20:12]).
  - inst[31:21]=11111000010 LDUR: imm = sext(inst[20:12]).
  - inst[31:22]=1001000100 ADDI: imm = zext(inst[21:10]).
  - inst[31:22]=1101000100 SUBI: imm = zext(inst[21:10]).
  - inst[31:21]=10001011000 ADD; 11001011000 SUB; 10001010000 AND; 10101010000 ORR: imm = 0.
  - inst[31:24]=10110100 CBZ; 10110101 CBNZ: imm = sext(inst[23:5]).
  - inst[31:26]=000101 B: imm = sext(inst[25:0]).
- Branch target:
  - Branches: out_br_target = in_pc + (imm << 2), truncated modulo 2^ADDR_W (wrap-around, no flag).
  - Non-branches: out_br_target = 0.
- Non-matching words:
  - inst = 0x00000000: OP_NOP, illegal=0.
  - Any other unmatched word: OP_NOP, illegal=1.
  - In both cases all flags and imm = 0. Still passes through the pipeline.
- Extension is to DATA_W. DATA_W must be ≥ 26; ADDR_W must be ≥ 28.

Decomposition:
- Package legv8_pkg holds:
  - op enum: OP_NOP=0, OP_LDUR=1, OP_STUR=2, OP_ADD=3, OP_SUB=4, OP_ADDI=5, OP_SUBI=6, OP_AND=7, OP_ORR=8, OP_CBZ=9, OP_CBNZ=10, OP_B=11.
  - opcode-pattern constants.
  - decoded-bundle struct.
- Sub-module legv8_decode_comb: pure combinational inst+pc → bundle.
- The stage wraps it with the handshake/skid registers.

Test Plan:
- ADDI X1,X2,#5: in_inst=0x91001441 → next cycle OP_ADDI, rd=1, rn=2, imm=5, reg_write=1, alu_imm=1, illegal=0.
- LDUR X3,[X4,#-8]: 0xF85F8083 → OP_LDUR, rd=3, rn=4, imm=0xFFFF_FFFF_FFFF_FFF8, mem_read=1, reg_write=1.
- CBZ X5,-4 at pc 0x100: 0xB4FFFF85 → OP_CBZ, rd=5, br_target=0xF0, is_branch=1. B at pc 0x200: 0x14000001 → br_target=0x204.
- Backpressure (SKID=1): stream pc 0x0,0x4,0x8 while out_ready=0 for 3 cycles → in_ready drops after two accepts, no loss; outputs stay stable; release yields pc order 0x0,0x4,0x8 back-to-back.
- Flush and reset: flush with two entries held and in_valid=1 → out_valid=0 next cycle, nothing emitted. rst_n=0 mid-stream → all outputs 0 next edge.
- Illegal: 0xFFFFFFFF → OP_NOP, illegal=1. 0x00000000 → OP_NOP, illegal=0. Both emitted with out_valid=1.
